// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-channel round-robin arbiter.
// Holds the FSM state type, the channel count and a one-hot helper.
package rr_arb_pkg;

   localparam int NCH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NCH-1:0] onehot4(input logic [1:0] i);
      onehot4 = 4'b0001 << i;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker for four requesters.
// Ports: req[3:0] requests, ptr[1:0] last owner (lowest priority);
//        any = some request set, idx[1:0] = first set bit after ptr.
module rr_pick4
   import rr_arb_pkg::*;
(
   input  logic [NCH-1:0] req,
   input  logic [1:0]     ptr,
   output logic           any,
   output logic [1:0]     idx
);

   // Walk from farthest (ptr+4 == ptr) to nearest (ptr+1) so the
   // nearest set bit is the last one written and therefore wins.
   always_comb begin
      logic [1:0] c;
      any = 1'b0;
      idx = ptr;
      c   = ptr;
      for (int k = NCH; k >= 1; k--) begin
         c = ptr + 2'(k);
         if (req[c]) begin
            any = 1'b1;
            idx = c;
         end
      end
   end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter for four channels with a bounded hold time.
// Ports: clk, rst (sync, active-high), req[3:0], done;
//        gnt[3:0] one-hot grant, valid, s1/s0 owner select (all registered).
module rr_arb4
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] req,
   input  logic           done,
   output logic [NCH-1:0] gnt,
   output logic           valid,
   output logic           s0,
   output logic           s1
);

   localparam int CW = $clog2(MAX_HOLD);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

   state_t         state;
   state_t         state_nxt;
   logic [1:0]     owner;
   logic [1:0]     owner_nxt;
   logic [1:0]     ptr;
   logic [1:0]     ptr_nxt;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nxt;
   logic [NCH-1:0] gnt_nxt;
   logic           valid_nxt;
   logic           pick_any;
   logic [1:0]     pick_idx;
   logic           rel;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      rel       = done | ~req[owner] | (cnt == CNT_LAST);
      unique case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = GRANT;
               owner_nxt = pick_idx;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            if (rel) begin
               // Owner becomes lowest priority for the next pick.
               state_nxt = IDLE;
               ptr_nxt   = owner;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Outputs are computed from next state and registered below;
      // owner is kept in IDLE so the mux select never moves.
      valid_nxt = (state_nxt == GRANT);
      gnt_nxt   = valid_nxt ? onehot4(owner_nxt) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= 2'd0;
         ptr   <= 2'd3;
         cnt   <= '0;
         gnt   <= '0;
         valid <= 1'b0;
         s0    <= 1'b0;
         s1    <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         valid <= valid_nxt;
         s0    <= owner_nxt[0];
         s1    <= owner_nxt[1];
      end
   end

endmodule

// File: tb/tb_rr_arb4.sv
// Testbench for rr_arb4: directed scenarios plus random traffic.
// Expected outputs come from a small cycle-level behavioural model.
module tb_rr_arb4;

   localparam int MH = 8;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic       valid;
   logic       s0;
   logic       s1;
   logic [6:0] obs;

   int n_vec;
   int n_err;

   // behavioural model state
   bit m_busy;
   int m_own;
   int m_ptr;
   int m_held;

   rr_arb4 #(.MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .done  (done),
      .gnt   (gnt),
      .valid (valid),
      .s0    (s0),
      .s1    (s1)
   );

   assign obs = {gnt, valid, s1, s0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] mexp();
      logic [3:0] g;
      logic [1:0] o;
      g = m_busy ? (4'b0001 << m_own) : 4'b0000;
      o = 2'(m_own);
      return {g, logic'(m_busy), o};
   endfunction

   // Apply inputs for one cycle, clock, advance the model, settle.
   task automatic step(input logic [3:0] r, input logic d,
                       input logic rs);
      req  = r;
      done = d;
      rst  = rs;
      @(posedge clk);
      if (rs) begin
         m_busy = 0; m_own = 0; m_ptr = 3; m_held = 0;
      end else if (!m_busy) begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (r[c]) begin
               m_busy = 1; m_own = c; m_held = 1;
               break;
            end
         end
      end else begin
         if (d || !r[m_own] || m_held == MH) begin
            m_busy = 0; m_ptr = m_own; m_held = 0;
         end else begin
            m_held++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      n_vec++;
      if (obs !== 7'b0000_0_00) begin
         n_err++;
         $display("FAIL reset got=%b exp=%b", obs, 7'b0000_0_00);
      end
      step(4'b0000, 1'b1, 1'b0);
      n_vec++;
      if (obs !== 7'b0000_0_00) begin
         n_err++;
         $display("FAIL idle_done got=%b exp=%b", obs, 7'b0000_0_00);
      end
   endtask

   task automatic test_single();
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0001, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 7'b0001_1_00) begin
         n_err++;
         $display("FAIL single_gnt got=%b exp=%b", obs, 7'b0001_1_00);
      end
      step(4'b0001, 1'b1, 1'b0);
      n_vec++;
      if (obs !== 7'b0000_0_00) begin
         n_err++;
         $display("FAIL single_rel got=%b exp=%b", obs, 7'b0000_0_00);
      end
   endtask

   task automatic test_rotation();
      logic [6:0] e;
      step(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         e = {4'b0001 << (i % 4), 1'b1, 2'(i % 4)};
         step(4'b1111, 1'b0, 1'b0);
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL rot_gnt%0d got=%b exp=%b", i, obs, e);
         end
         step(4'b1111, 1'b0, 1'b0);
         step(4'b1111, 1'b1, 1'b0);
         e = {4'b0000, 1'b0, 2'(i % 4)};
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL rot_idle%0d got=%b exp=%b", i, obs, e);
         end
      end
   endtask

   task automatic test_max_hold();
      step(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < MH; i++) begin
         step(4'b0100, 1'b0, 1'b0);
         n_vec++;
         if (obs !== 7'b0100_1_10) begin
            n_err++;
            $display("FAIL hold_cyc%0d got=%b exp=%b", i, obs,
                     7'b0100_1_10);
         end
      end
      step(4'b0100, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 7'b0000_0_10) begin
         n_err++;
         $display("FAIL hold_bubble got=%b exp=%b", obs, 7'b0000_0_10);
      end
      step(4'b0100, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 7'b0100_1_10) begin
         n_err++;
         $display("FAIL hold_regnt got=%b exp=%b", obs, 7'b0100_1_10);
      end
   endtask

   task automatic test_nonowner();
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0010, 1'b0, 1'b0);
      step(4'b1010, 1'b0, 1'b0);
      step(4'b1010, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 7'b0010_1_01) begin
         n_err++;
         $display("FAIL nonowner got=%b exp=%b", obs, 7'b0010_1_01);
      end
      step(4'b1000, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 7'b0000_0_01) begin
         n_err++;
         $display("FAIL drop_rel got=%b exp=%b", obs, 7'b0000_0_01);
      end
      step(4'b1000, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 7'b1000_1_11) begin
         n_err++;
         $display("FAIL next_ch3 got=%b exp=%b", obs, 7'b1000_1_11);
      end
   endtask

   task automatic test_reset_mid();
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b1);
      n_vec++;
      if (obs !== 7'b0000_0_00) begin
         n_err++;
         $display("FAIL rst_mid got=%b exp=%b", obs, 7'b0000_0_00);
      end
      step(4'b1111, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 7'b0001_1_00) begin
         n_err++;
         $display("FAIL rst_first got=%b exp=%b", obs, 7'b0001_1_00);
      end
   endtask

   task automatic test_dual_release();
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      n_vec++;
      if (obs !== 7'b0000_0_01) begin
         n_err++;
         $display("FAIL dual_rel got=%b exp=%b", obs, 7'b0000_0_01);
      end
      step(4'b0110, 1'b0, 1'b0);
      n_vec++;
      if (obs !== 7'b0100_1_10) begin
         n_err++;
         $display("FAIL dual_ptr got=%b exp=%b", obs, 7'b0100_1_10);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       d;
      logic       rs;
      r = 4'b0000;
      step(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0)
            r = 4'($urandom_range(0, 15));
         d  = ($urandom_range(0, 5) == 0);
         rs = ($urandom_range(0, 99) == 0);
         step(r, d, rs);
         n_vec++;
         if (obs !== mexp()) begin
            n_err++;
            $display("FAIL random%0d req=%b got=%b exp=%b", i, r, obs,
                     mexp());
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_busy = 0; m_own = 0; m_ptr = 3; m_held = 0;
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_max_hold();
      test_nonowner();
      test_reset_mid();
      test_dual_release();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
